// File: rtl/aes_enc_host_if_if.sv
// Host/core signal bundle for aes_enc_host_if: host register port, read port and core handshake.
// slave = the front-end block, master = host plus core environment.
interface aes_enc_host_if_if #(
   parameter int unsigned N_BYTES    = 16,
   parameter int unsigned NFLAGS     = 8,
   parameter int unsigned N_ADDR     = 2,
   parameter int unsigned FIFO_DEPTH = 4
);
   localparam int unsigned DW = N_BYTES * 8;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic              wr_en;
   logic [N_ADDR-1:0] addr;
   logic [DW-1:0]     wdata;
   logic              rd_en;
   logic [DW-1:0]     rdata;
   logic              rd_valid;
   logic              core_start;
   logic [DW-1:0]     core_plaintext;
   logic [NFLAGS-1:0] core_flags;
   logic              core_done;
   logic [DW-1:0]     core_encData;
   logic              busy;
   logic [CW-1:0]     in_count;
   logic [CW-1:0]     out_count;
   logic              overflow;
   logic              timeout;

   modport slave (
      input  wr_en, addr, wdata, rd_en, core_done, core_encData,
      output rdata, rd_valid, core_start, core_plaintext, core_flags,
             busy, in_count, out_count, overflow, timeout
   );

   modport master (
      output wr_en, addr, wdata, rd_en, core_done, core_encData,
      input  rdata, rd_valid, core_start, core_plaintext, core_flags,
             busy, in_count, out_count, overflow, timeout
   );
endinterface

// File: rtl/aes_enc_host_if.sv
// Host front-end for one AES-256 encryption core: register map, input/output block FIFOs
// and a start/done sequencer. Optional WAIT watchdog enabled by defining AES_ENC_TIMEOUT_EN.
module aes_enc_host_if #(
   parameter int unsigned N_BYTES        = 16,
   parameter int unsigned NFLAGS         = 8,
   parameter int unsigned N_ADDR         = 2,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic                 clk,
   input logic                 reset,
   aes_enc_host_if_if.slave    bus
);
   localparam int unsigned DW = N_BYTES * 8;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [N_ADDR-1:0] A_CTRL = N_ADDR'(0);
   localparam logic [N_ADDR-1:0] A_DATA = N_ADDR'(1);
   localparam logic [N_ADDR-1:0] A_CMD  = N_ADDR'(2);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2 ||
       NFLAGS < 1 || NFLAGS > DW) begin : g_param_check
      $error("aes_enc_host_if: illegal parameter combination");
   end

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_STORE} state_t;

   state_t            r_state;
   logic              r_core_start;
   logic              r_busy;
   logic [DW-1:0]     r_core_pt;
   logic [DW-1:0]     r_cap;
   logic [NFLAGS-1:0] r_ctrl;
   logic              r_overflow;
   logic [DW-1:0]     r_rdata;
   logic              r_rd_valid;

   logic [DW-1:0]     r_in_mem [FIFO_DEPTH];
   logic [PW-1:0]     r_in_wr;
   logic [PW-1:0]     r_in_rd;
   logic [CW-1:0]     r_in_count;
   logic [DW-1:0]     r_out_mem [FIFO_DEPTH];
   logic [PW-1:0]     r_out_wr;
   logic [PW-1:0]     r_out_rd;
   logic [CW-1:0]     r_out_count;

   logic w_wr_ctrl, w_wr_data, w_wr_cmd, w_flush, w_clr_err;
   logic w_in_full, w_in_empty, w_out_full, w_out_empty;
   logic w_in_push, w_in_pop, w_out_push, w_out_pop;
   logic w_launch, w_wd_expire;

   // Register decode
   assign w_wr_ctrl = bus.wr_en && (bus.addr == A_CTRL);
   assign w_wr_data = bus.wr_en && (bus.addr == A_DATA);
   assign w_wr_cmd  = bus.wr_en && (bus.addr == A_CMD);
   assign w_flush   = w_wr_cmd && bus.wdata[0];
   assign w_clr_err = w_wr_cmd && bus.wdata[1];

   assign w_in_full   = (r_in_count == CW'(FIFO_DEPTH));
   assign w_in_empty  = (r_in_count == CW'(0));
   assign w_out_full  = (r_out_count == CW'(FIFO_DEPTH));
   assign w_out_empty = (r_out_count == CW'(0));

   // Launch only when the result already has a reserved output slot
   assign w_launch   = (r_state == S_IDLE) && r_ctrl[0] && !w_in_empty && !w_out_full;
   assign w_in_push  = w_wr_data && !w_in_full;
   assign w_in_pop   = w_launch;
   assign w_out_push = (r_state == S_STORE);
   assign w_out_pop  = bus.rd_en && !w_out_empty && !w_flush;

   always_ff @(posedge clk) begin
      if (w_in_push) r_in_mem[r_in_wr] <= bus.wdata;
      if (w_out_push) r_out_mem[r_out_wr] <= r_cap;
   end

   // Input FIFO pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_wr    <= '0;
         r_in_rd    <= '0;
         r_in_count <= '0;
      end else if (w_flush) begin
         r_in_wr    <= '0;
         r_in_rd    <= '0;
         r_in_count <= '0;
      end else begin
         if (w_in_push) r_in_wr <= r_in_wr + PW'(1);
         if (w_in_pop)  r_in_rd <= r_in_rd + PW'(1);
         case ({w_in_push, w_in_pop})
            2'b10:   r_in_count <= r_in_count + CW'(1);
            2'b01:   r_in_count <= r_in_count - CW'(1);
            default: r_in_count <= r_in_count;
         endcase
      end
   end

   // Output FIFO pointers, occupancy and host read port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_wr    <= '0;
         r_out_rd    <= '0;
         r_out_count <= '0;
         r_rdata     <= '0;
         r_rd_valid  <= 1'b0;
      end else if (w_flush) begin
         r_out_wr    <= '0;
         r_out_rd    <= '0;
         r_out_count <= '0;
         r_rd_valid  <= 1'b0;
      end else begin
         r_rd_valid <= w_out_pop;
         if (w_out_pop) begin
            r_rdata  <= r_out_mem[r_out_rd];
            r_out_rd <= r_out_rd + PW'(1);
         end
         if (w_out_push) r_out_wr <= r_out_wr + PW'(1);
         case ({w_out_push, w_out_pop})
            2'b10:   r_out_count <= r_out_count + CW'(1);
            2'b01:   r_out_count <= r_out_count - CW'(1);
            default: r_out_count <= r_out_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ctrl     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_ctrl) r_ctrl <= bus.wdata[NFLAGS-1:0];
         if (w_clr_err) r_overflow <= 1'b0;
         else if (w_wr_data && w_in_full) r_overflow <= 1'b1;
      end
   end

`ifdef AES_ENC_TIMEOUT_EN
   localparam int unsigned WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [WD_W-1:0] r_wd_cnt;
   logic            r_timeout;

   assign w_wd_expire = (r_state == S_WAIT) && !bus.core_done && !w_flush &&
                        (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   // Watchdog counts WAIT cycles; restarts on every entry to WAIT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wd_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == S_START)     r_wd_cnt <= '0;
         else if (r_state == S_WAIT) r_wd_cnt <= r_wd_cnt + WD_W'(1);
         if (w_clr_err)        r_timeout <= 1'b0;
         else if (w_wd_expire) r_timeout <= 1'b1;
      end
   end

   assign bus.timeout = r_timeout;
`else
   assign w_wd_expire = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   // Sequencer: one block in flight, core_done honoured only in WAIT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_core_start <= 1'b0;
         r_busy       <= 1'b0;
         r_core_pt    <= '0;
         r_cap        <= '0;
      end else if (w_flush) begin
         r_state      <= S_IDLE;
         r_core_start <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_core_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_launch) begin
                  r_state      <= S_START;
                  r_core_start <= 1'b1;
                  r_busy       <= 1'b1;
                  r_core_pt    <= r_in_mem[r_in_rd];
               end
            end
            S_START: r_state <= S_WAIT;
            S_WAIT: begin
               if (bus.core_done) begin
                  r_cap   <= bus.core_encData;
                  r_state <= S_STORE;
               end else if (w_wd_expire) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            S_STORE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rdata          = r_rdata;
   assign bus.rd_valid       = r_rd_valid;
   assign bus.core_start     = r_core_start;
   assign bus.core_plaintext = r_core_pt;
   assign bus.core_flags     = r_ctrl;
   assign bus.busy           = r_busy;
   assign bus.in_count       = r_in_count;
   assign bus.out_count      = r_out_count;
   assign bus.overflow       = r_overflow;
endmodule

// File: doc/aes_enc_host_if.md
Name: aes_enc_host_if

Overview:
- Parametrised host front-end for the AES-256 encryption core.
- Replaces the single-register addr/plaintext interface with three pieces:
  - a decoded register map;
  - an input block FIFO and an output ciphertext FIFO;
  - a sequencer that feeds the core one block at a time through a start/done handshake.
- Sits between the bus/host logic and one AES256 encryption core instance, so the host can queue several blocks back-to-back.

Parameters:
- N_BYTES, 16, block size in bytes; data buses are N_BYTES*8 bits.
- NFLAGS, 8, width of the control/flags register forwarded to the core.
- N_ADDR, 2, host address width.
- FIFO_DEPTH, 4, entries in each FIFO; power of two, minimum 2.
- TIMEOUT_CYCLES, 255, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  host write strobe.
- addr  in  N_ADDR  register select: 0=CTRL, 1=DATA_IN, 2=CMD, 3=reserved.
- wdata  in  N_BYTES*8  host write data.
- rd_en  in  1  pop request for the output FIFO.
- rdata  out  N_BYTES*8  ciphertext, registered.
- rd_valid  out  1  rdata valid for one cycle.
- core_start  out  1  one-cycle start pulse to the core.
- core_plaintext  out  N_BYTES*8  block presented to the core; held from START through WAIT.
- core_flags  out  NFLAGS  CTRL register contents.
- core_done  in  1  completion pulse from the core.
- core_encData  in  N_BYTES*8  ciphertext; valid while core_done=1.
- busy  out  1  sequencer is not in IDLE.
- in_count  out  $clog2(FIFO_DEPTH)+1  input FIFO occupancy.
- out_count  out  $clog2(FIFO_DEPTH)+1  output FIFO occupancy.
- overflow  out  1  sticky: a DATA_IN write was dropped.
- timeout  out  1  sticky watchdog flag; tied 0 without the optional feature.

Behaviour:
- Reset:
  - All outputs are 0; CTRL=0; both FIFOs are empty; state=IDLE.
  - Reset mid-operation aborts the in-flight block. core_done arriving after reset release while in IDLE is ignored.
- Register writes (wr_en=1):
  - CTRL: CTRL <= wdata[NFLAGS-1:0]. CTRL[0] is ENABLE.
  - DATA_IN: push wdata to the input FIFO. If the FIFO is full, drop the write and set overflow.
  - CMD:
    - bit0 flushes both FIFOs and returns the FSM to IDLE.
    - bit1 clears overflow and timeout.
    - If both bits are set, both actions happen in the same cycle.
  - Reserved address: ignored.
- FIFOs:
  - Circular pointers that wrap at FIFO_DEPTH.
  - A simultaneous push and pop on the same FIFO in one cycle is legal at any occupancy except a push when full.
  - The count is unchanged on a simultaneous push and pop.
- Host read:
  - rd_en with the output FIFO non-empty: the next cycle has rd_valid=1 and rdata = head entry, and the entry is popped.
  - rd_en with the output FIFO empty: rd_valid=0, rdata holds its previous value, no error.
- FSM states: IDLE, START, WAIT, STORE.
  - IDLE -> START when ENABLE=1, in_count>0 and out_count<FIFO_DEPTH.
    - The edge into START pops the input head into core_plaintext.
  - START: core_start=1 for exactly this cycle; next state WAIT.
  - WAIT: when core_done=1, capture core_encData and go to STORE. Otherwise stay.
  - STORE: push the capture into the output FIFO; next state IDLE.
    - The reservation check made in IDLE guarantees space.
- Latency:
  - A DATA_IN write accepted at edge t gives core_start high in the cycle after edge t+1.
  - core_done at edge d makes the result readable via rd_en from the cycle after edge d+1.
  - Minimum overhead is 3 cycles per block plus the core latency.
- Clearing ENABLE during START/WAIT/STORE finishes the current block, then the FSM holds in IDLE.
- CMD flush during WAIT discards the in-flight block, and a later core_done is ignored.
- The FSM samples core_done only in WAIT.

Optional Feature:
- Macro: AES_ENC_TIMEOUT_EN.
- Defined:
  - An 8+ bit watchdog counter runs in WAIT.
  - If TIMEOUT_CYCLES cycles pass without core_done, the FSM sets timeout, drops the block and returns to IDLE.
  - The counter clears on every entry to WAIT.
- Undefined: no counter; WAIT waits indefinitely; timeout=0.

Test Plan:
- Single block:
  - Stimulus: reset; CTRL=0x01; DATA_IN=0x00000101030307070f0f1f1f3f3f7f7f. The bench core model returns 0xcc6f84800354f24a045f32ee85ff2d4b after 60 cycles.
  - Required: exactly one core_start pulse 2 cycles after the write. After rd_en, rd_valid=1 with rdata=0xcc6f84800354f24a045f32ee85ff2d4b.
- Back-to-back queueing:
  - Stimulus: model core = XOR 0xFF..FF with 10-cycle latency; write 4 blocks 0x1..0x4 with ENABLE=0; in_count=4. Then set ENABLE.
  - Required: 4 core_start pulses in order. rd returns ~0x1..~0x4 in order. in_count reaches 0.
- Overflow:
  - Stimulus: ENABLE=0; write 5 blocks.
  - Required: in_count=4 and overflow=1. CMD bit1 then clears overflow.
- Output full back-pressure:
  - Stimulus: ENABLE=1, no rd_en, 5 blocks written.
  - Required: 4 completed, 5th waits in the input FIFO with busy=0 and no 5th core_start. One rd_en releases it.
- Flush / reset mid-operation:
  - Stimulus: CMD=0x1 during WAIT, then a late core_done.
  - Required: counts go to 0, FSM returns to IDLE, nothing is stored.
  - Repeat with reset asserted during WAIT: all outputs are 0 asynchronously.
- Timeout (AES_ENC_TIMEOUT_EN, TIMEOUT_CYCLES=20):
  - Stimulus: a core that never asserts done.
  - Required: timeout=1 and busy=0 20 cycles after core_start; out_count=0.
